cdb_arbiter: RTL

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 14 +
 rtl/cdb_arbiter_rr_picker.sv | 24 ++
 rtl/cdb_arbiter.sv | 63 ++++++
 3 files changed

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared CDB result record and functional-unit port indices.
package types;
    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic [5:0]  preg;
        logic [4:0]  rob_id;
    } cdb_t;
    localparam int NUM_CDB_REQ  = 4;
    localparam int CDB_PORT_ALU = 0;
    localparam int CDB_PORT_MUL = 1;
    localparam int CDB_PORT_DIV = 2;
    localparam int CDB_PORT_LSU = 3;
endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// rr_picker: round-robin one-hot picker; the first set req at or after ptr wins.
module rr_picker #(
    parameter int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_o
);
    logic found;
    int   idx;
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_i) + i) % N;
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin common-data-bus arbiter with a registered broadcast
// and a contention counter that survives flush.
module cdb_arbiter
    import types::*;
#(
    parameter int NUM_REQ = NUM_CDB_REQ,
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  cdb_t               fu_cdb [NUM_REQ],
    output logic [NUM_REQ-1:0] cdb_grant,
    output cdb_t               cdb_out,
    output logic [31:0]        contention_cnt
);
    logic [NUM_REQ-1:0] valid, pick;
    logic [PW-1:0]      ptr_q, ptr_d;
    cdb_t               cdb_q, cdb_d, sel;
    logic [31:0]        cnt_q, cnt_d;
    logic               kill, multi;

    rr_picker #(.N(NUM_REQ)) u_pick (
        .req_i (valid),
        .ptr_i (ptr_q),
        .gnt_o (pick)
    );

    always_comb begin
        valid = '0;
        for (int i = 0; i < NUM_REQ; i++) valid[i] = fu_cdb[i].valid;
        kill      = rst || flush;
        multi     = $countones(valid) > 1;
        cdb_grant = kill ? '0 : pick;
        sel       = '0;
        ptr_d     = ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (cdb_grant[i]) begin
                sel   = fu_cdb[i];
                ptr_d = (i == NUM_REQ - 1) ? '0 : PW'(i + 1);
            end
        end
        ptr_d = kill ? '0 : ptr_d;
        // Idle cycles drop valid but keep the last payload on the bus.
        cdb_d       = cdb_q;
        cdb_d.valid = 1'b0;
        if (|cdb_grant) begin
            cdb_d       = sel;
            cdb_d.valid = 1'b1;
        end
        if (kill) cdb_d = '0;
        cnt_d = rst ? '0 : cnt_q + 32'(multi);
    end

    always_ff @(posedge clk) begin
        ptr_q <= ptr_d;
        cdb_q <= cdb_d;
        cnt_q <= cnt_d;
    end

    assign cdb_out        = cdb_q;
    assign contention_cnt = cnt_q;
endmodule
